// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ID/EX ALU issue stage: ALU op codes, MIPS opcode/funct
// values, branch and access-size encodings, and the decode/EX-register structs.
package alu_ctrl_pkg;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluMul  = 4'b0010;
  localparam logic [3:0] AluBgez = 4'b0011;
  localparam logic [3:0] AluBgtz = 4'b0100;
  localparam logic [3:0] AluBlez = 4'b0101;
  localparam logic [3:0] AluBltz = 4'b0110;
  localparam logic [3:0] AluAnd  = 4'b0111;
  localparam logic [3:0] AluOr   = 4'b1000;
  localparam logic [3:0] AluNor  = 4'b1001;
  localparam logic [3:0] AluXor  = 4'b1010;
  localparam logic [3:0] AluSll  = 4'b1011;
  localparam logic [3:0] AluSrl  = 4'b1111;

  localparam logic [5:0] OpRtype  = 6'h00;
  localparam logic [5:0] OpRegimm = 6'h01;
  localparam logic [5:0] OpBeq    = 6'h04;
  localparam logic [5:0] OpBne    = 6'h05;
  localparam logic [5:0] OpBlez   = 6'h06;
  localparam logic [5:0] OpBgtz   = 6'h07;
  localparam logic [5:0] OpAddi   = 6'h08;
  localparam logic [5:0] OpSlti   = 6'h0A;
  localparam logic [5:0] OpAndi   = 6'h0C;
  localparam logic [5:0] OpOri    = 6'h0D;
  localparam logic [5:0] OpXori   = 6'h0E;
  localparam logic [5:0] OpMul    = 6'h1C;
  localparam logic [5:0] OpLb     = 6'h20;
  localparam logic [5:0] OpLh     = 6'h21;
  localparam logic [5:0] OpLw     = 6'h23;
  localparam logic [5:0] OpSb     = 6'h28;
  localparam logic [5:0] OpSh     = 6'h29;
  localparam logic [5:0] OpSw     = 6'h2B;

  localparam logic [5:0] FnSll = 6'h00;
  localparam logic [5:0] FnSrl = 6'h02;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnXor = 6'h26;
  localparam logic [5:0] FnNor = 6'h27;
  localparam logic [5:0] FnSlt = 6'h2A;
  localparam logic [5:0] FnMul = 6'h02;

  localparam logic [2:0] BrNone = 3'd0;
  localparam logic [2:0] BrBeq  = 3'd1;
  localparam logic [2:0] BrBne  = 3'd2;
  localparam logic [2:0] BrBgez = 3'd3;
  localparam logic [2:0] BrBgtz = 3'd4;
  localparam logic [2:0] BrBlez = 3'd5;
  localparam logic [2:0] BrBltz = 3'd6;

  localparam logic [1:0] MemWord = 2'b00;
  localparam logic [1:0] MemHalf = 2'b01;
  localparam logic [1:0] MemByte = 2'b10;

  localparam logic [1:0] BSelRt    = 2'd0;
  localparam logic [1:0] BSelShamt = 2'd1;
  localparam logic [1:0] BSelImm   = 2'd2;
  localparam logic [1:0] BSelZero  = 2'd3;

  localparam logic [1:0] DstNone = 2'd0;
  localparam logic [1:0] DstRd   = 2'd1;
  localparam logic [1:0] DstRt   = 2'd2;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       a_rt;      // operand A from rt (shifts) instead of rs
    logic [1:0] b_sel;
    logic       imm_sext;
    logic [1:0] dst_sel;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
    logic       slt_sel;
    logic [2:0] br_type;
    logic       illegal;
    logic       uses_rs;
    logic       uses_rt;
  } dec_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  wreg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        slt_sel;
    logic [2:0]  br_type;
  } ex_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational MIPS decoder: opcode/rt/funct to ALU op, operand selects,
// immediate extension, control bits and an illegal-instruction flag.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [4:0] rt_i,
  input  logic [5:0] funct_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '0;
    dec_o.uses_rs = 1'b1;
    dec_o.b_sel   = BSelRt;
    case (op_i)
      OpRtype: begin
        dec_o.dst_sel   = DstRd;
        dec_o.reg_write = 1'b1;
        dec_o.uses_rt   = 1'b1;
        case (funct_i)
          FnAdd: dec_o.alu_op = AluAdd;
          FnSub: dec_o.alu_op = AluSub;
          FnAnd: dec_o.alu_op = AluAnd;
          FnOr:  dec_o.alu_op = AluOr;
          FnXor: dec_o.alu_op = AluXor;
          FnNor: dec_o.alu_op = AluNor;
          FnSlt: begin
            dec_o.alu_op  = AluSub;
            dec_o.slt_sel = 1'b1;
          end
          FnSll, FnSrl: begin
            dec_o.alu_op  = (funct_i == FnSll) ? AluSll : AluSrl;
            dec_o.a_rt    = 1'b1;
            dec_o.b_sel   = BSelShamt;
            dec_o.uses_rs = 1'b0;
          end
          default: dec_o.illegal = 1'b1;
        endcase
      end
      OpMul: begin
        dec_o.alu_op    = AluMul;
        dec_o.dst_sel   = DstRd;
        dec_o.reg_write = 1'b1;
        dec_o.uses_rt   = 1'b1;
        dec_o.illegal   = (funct_i != FnMul);
      end
      OpAddi, OpSlti, OpAndi, OpOri, OpXori: begin
        dec_o.b_sel     = BSelImm;
        dec_o.dst_sel   = DstRt;
        dec_o.reg_write = 1'b1;
        dec_o.imm_sext  = (op_i == OpAddi) || (op_i == OpSlti);
        dec_o.slt_sel   = (op_i == OpSlti);
        case (op_i)
          OpAddi:  dec_o.alu_op = AluAdd;
          OpSlti:  dec_o.alu_op = AluSub;
          OpAndi:  dec_o.alu_op = AluAnd;
          OpOri:   dec_o.alu_op = AluOr;
          default: dec_o.alu_op = AluXor;
        endcase
      end
      OpLw, OpLh, OpLb: begin
        dec_o.alu_op    = AluAdd;
        dec_o.b_sel     = BSelImm;
        dec_o.imm_sext  = 1'b1;
        dec_o.dst_sel   = DstRt;
        dec_o.reg_write = 1'b1;
        dec_o.mem_read  = 1'b1;
        dec_o.mem_size  = (op_i == OpLw) ? MemWord : (op_i == OpLh) ? MemHalf : MemByte;
      end
      OpSw, OpSh, OpSb: begin
        dec_o.alu_op    = AluAdd;
        dec_o.b_sel     = BSelImm;
        dec_o.imm_sext  = 1'b1;
        dec_o.mem_write = 1'b1;
        dec_o.uses_rt   = 1'b1;
        dec_o.mem_size  = (op_i == OpSw) ? MemWord : (op_i == OpSh) ? MemHalf : MemByte;
      end
      OpBeq, OpBne: begin
        dec_o.alu_op  = AluSub;
        dec_o.uses_rt = 1'b1;
        dec_o.br_type = (op_i == OpBeq) ? BrBeq : BrBne;
      end
      OpBlez, OpBgtz: begin
        dec_o.alu_op  = (op_i == OpBlez) ? AluBlez : AluBgtz;
        dec_o.b_sel   = BSelZero;
        dec_o.br_type = (op_i == OpBlez) ? BrBlez : BrBgtz;
      end
      OpRegimm: begin
        dec_o.b_sel = BSelZero;
        case (rt_i)
          5'd1: begin
            dec_o.alu_op  = AluBgez;
            dec_o.br_type = BrBgez;
          end
          5'd0: begin
            dec_o.alu_op  = AluBltz;
            dec_o.br_type = BrBltz;
          end
          default: dec_o.illegal = 1'b1;
        endcase
      end
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX issue stage: decodes the ID instruction into ALU operands/controls, registers
// them into EX with flush/stall/hazard priority, and flags load-use hazards.
module id_ex_alu_issue
  import alu_ctrl_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        InValid,
  input  logic [31:0] Instr,
  input  logic [31:0] RsData,
  input  logic [31:0] RtData,
  input  logic        Stall,
  input  logic        Flush,
  output logic        HazardStall,
  output logic        OutValid,
  output logic [3:0]  ALUControl,
  output logic [31:0] OperandA,
  output logic [31:0] OperandB,
  output logic [4:0]  WriteReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [1:0]  MemSize,
  output logic        SltSel,
  output logic [2:0]  BrType,
  output logic        IllegalInstr
);

  dec_t       dec;
  ex_t        ex_q, ex_d, ex_new;
  logic       illegal_q, illegal_d;
  logic [4:0] rs, rt, rd;
  logic [31:0] imm;

  assign rs = Instr[25:21];
  assign rt = Instr[20:16];
  assign rd = Instr[15:11];

  alu_ctrl_decode u_decode (
    .op_i    (Instr[31:26]),
    .rt_i    (rt),
    .funct_i (Instr[5:0]),
    .dec_o   (dec)
  );

  assign imm = dec.imm_sext ? {{16{Instr[15]}}, Instr[15:0]} : {16'h0000, Instr[15:0]};

  // Load-use check against the instruction currently sitting in EX.
  assign HazardStall = ex_q.valid && ex_q.mem_read && (ex_q.wreg != 5'd0) && InValid &&
                       ((dec.uses_rs && (rs == ex_q.wreg)) || (dec.uses_rt && (rt == ex_q.wreg)));

  always_comb begin
    ex_new           = '0;
    ex_new.valid     = 1'b1;
    ex_new.alu_op    = dec.alu_op;
    ex_new.op_a      = dec.a_rt ? RtData : RsData;
    case (dec.b_sel)
      BSelRt:    ex_new.op_b = RtData;
      BSelShamt: ex_new.op_b = {27'd0, Instr[10:6]};
      BSelImm:   ex_new.op_b = imm;
      default:   ex_new.op_b = 32'd0;
    endcase
    case (dec.dst_sel)
      DstRd:   ex_new.wreg = rd;
      DstRt:   ex_new.wreg = rt;
      default: ex_new.wreg = 5'd0;
    endcase
    ex_new.reg_write = dec.reg_write && (ex_new.wreg != 5'd0);
    ex_new.mem_read  = dec.mem_read;
    ex_new.mem_write = dec.mem_write;
    ex_new.mem_size  = dec.mem_size;
    ex_new.slt_sel   = dec.slt_sel;
    ex_new.br_type   = dec.br_type;
  end

  always_comb begin
    ex_d      = '0;
    illegal_d = 1'b0;
    if (Flush) begin
      ex_d = '0;
    end else if (Stall) begin
      ex_d = ex_q;
    end else if (HazardStall || !InValid) begin
      ex_d = '0;
    end else if (dec.illegal) begin
      illegal_d = 1'b1;
    end else begin
      ex_d = ex_new;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ex_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      ex_q      <= ex_d;
      illegal_q <= illegal_d;
    end
  end

  assign OutValid     = ex_q.valid;
  assign ALUControl   = ex_q.alu_op;
  assign OperandA     = ex_q.op_a;
  assign OperandB     = ex_q.op_b;
  assign WriteReg     = ex_q.wreg;
  assign RegWrite     = ex_q.reg_write;
  assign MemRead      = ex_q.mem_read;
  assign MemWrite     = ex_q.mem_write;
  assign MemSize      = ex_q.mem_size;
  assign SltSel       = ex_q.slt_sel;
  assign BrType       = ex_q.br_type;
  assign IllegalInstr = illegal_q;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Directed bench for id_ex_alu_issue: hand-encoded MIPS words with hand-computed
// EX-register contents, load-use hazard, stall/flush priority and async reset.
module tb_id_ex_alu_issue;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        InValid;
  logic [31:0] Instr, RsData, RtData;
  logic        Stall, Flush;
  logic        HazardStall, OutValid, RegWrite, MemRead, MemWrite, SltSel, IllegalInstr;
  logic [3:0]  ALUControl;
  logic [31:0] OperandA, OperandB;
  logic [4:0]  WriteReg;
  logic [1:0]  MemSize;
  logic [2:0]  BrType;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  id_ex_alu_issue dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .InValid      (InValid),
    .Instr        (Instr),
    .RsData       (RsData),
    .RtData       (RtData),
    .Stall        (Stall),
    .Flush        (Flush),
    .HazardStall  (HazardStall),
    .OutValid     (OutValid),
    .ALUControl   (ALUControl),
    .OperandA     (OperandA),
    .OperandB     (OperandB),
    .WriteReg     (WriteReg),
    .RegWrite     (RegWrite),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemSize      (MemSize),
    .SltSel       (SltSel),
    .BrType       (BrType),
    .IllegalInstr (IllegalInstr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    InValid = 1'b1;
    Instr   = ins;
    RsData  = rs;
    RtData  = rt;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst_n = 1'b0; InValid = 1'b0; Instr = '0; RsData = '0; RtData = '0;
    Stall = 1'b0; Flush = 1'b0;
    #1;
    check("rst_valid", 32'(OutValid), 32'd0);
    check("rst_alu", 32'(ALUControl), 32'd0);
    check("rst_ill", 32'(IllegalInstr), 32'd0);
    #11 Rst_n = 1'b1;

    // add $8,$9,$10
    issue(32'h012A4020, 32'd5, 32'd7); tick();
    check("add_valid", 32'(OutValid), 32'd1);
    check("add_alu", 32'(ALUControl), 32'h0);
    check("add_a", OperandA, 32'd5);
    check("add_b", OperandB, 32'd7);
    check("add_wreg", 32'(WriteReg), 32'd8);
    check("add_rw", 32'(RegWrite), 32'd1);

    // andi $8,$9,0xFFFF (zero-extend) vs addi (sign-extend)
    issue(32'h3128FFFF, 32'd3, 32'd0); tick();
    check("andi_alu", 32'(ALUControl), 32'h7);
    check("andi_b", OperandB, 32'h0000FFFF);
    check("andi_a", OperandA, 32'd3);
    issue(32'h2128FFFF, 32'd3, 32'd0); tick();
    check("addi_alu", 32'(ALUControl), 32'h0);
    check("addi_b", OperandB, 32'hFFFFFFFF);

    // sll $8,$9,4: A from rt, B = shamt
    issue(32'h00094100, 32'h11, 32'h80); tick();
    check("sll_alu", 32'(ALUControl), 32'hB);
    check("sll_a", OperandA, 32'h80);
    check("sll_b", OperandB, 32'd4);

    // NOP word: SLL with no register write
    issue(32'h00000000, 32'h11, 32'h22); tick();
    check("nop_alu", 32'(ALUControl), 32'hB);
    check("nop_rw", 32'(RegWrite), 32'd0);
    check("nop_valid", 32'(OutValid), 32'd1);

    issue(32'h012A402A, 32'd1, 32'd2); tick();
    check("slt_alu", 32'(ALUControl), 32'h1);
    check("slt_sel", 32'(SltSel), 32'd1);

    // sw $8,-4($9)
    issue(32'hAD28FFFC, 32'h100, 32'h55); tick();
    check("sw_mw", 32'(MemWrite), 32'd1);
    check("sw_rw", 32'(RegWrite), 32'd0);
    check("sw_a", OperandA, 32'h100);
    check("sw_b", OperandB, 32'hFFFFFFFC);

    // lb $8,4($9)
    issue(32'h81280004, 32'h200, 32'h0); tick();
    check("lb_mr", 32'(MemRead), 32'd1);
    check("lb_size", 32'(MemSize), 32'd2);
    check("lb_b", OperandB, 32'd4);

    // bgez $9
    issue(32'h05210000, 32'h9, 32'h77); tick();
    check("bgez_alu", 32'(ALUControl), 32'h3);
    check("bgez_br", 32'(BrType), 32'd3);
    check("bgez_rw", 32'(RegWrite), 32'd0);
    check("bgez_b", OperandB, 32'd0);

    // lw $8,0($9) then add $10,$8,$8 -> one bubble
    issue(32'h8D280000, 32'h40, 32'h0); tick();
    check("lw_mr", 32'(MemRead), 32'd1);
    check("lw_wreg", 32'(WriteReg), 32'd8);
    issue(32'h01085020, 32'd1, 32'd2); #1;
    check("hz_on", 32'(HazardStall), 32'd1);
    tick();
    check("hz_bubble", 32'(OutValid), 32'd0);
    check("hz_bubble_rw", 32'(RegWrite), 32'd0);
    check("hz_off", 32'(HazardStall), 32'd0);
    tick();
    check("hz_issue_valid", 32'(OutValid), 32'd1);
    check("hz_issue_wreg", 32'(WriteReg), 32'd10);
    check("hz_issue_a", OperandA, 32'd1);

    // Stall holds the add; Stall+Flush kills it
    Stall = 1'b1;
    issue(32'h3128FFFF, 32'd3, 32'd0); tick();
    check("stall_wreg", 32'(WriteReg), 32'd10);
    check("stall_alu", 32'(ALUControl), 32'h0);
    check("stall_valid", 32'(OutValid), 32'd1);
    Flush = 1'b1; tick();
    check("flush_valid", 32'(OutValid), 32'd0);
    check("flush_rw", 32'(RegWrite), 32'd0);
    Stall = 1'b0; Flush = 1'b0;

    // Illegal opcode 0x3F
    issue(32'hFC000000, 32'd1, 32'd1); tick();
    check("ill_pulse", 32'(IllegalInstr), 32'd1);
    check("ill_valid", 32'(OutValid), 32'd0);
    InValid = 1'b0; tick();
    check("ill_clear", 32'(IllegalInstr), 32'd0);

    // Async reset mid-stall
    issue(32'h012A4020, 32'd5, 32'd7); tick();
    check("pre_rst_valid", 32'(OutValid), 32'd1);
    Stall = 1'b1;
    #2 Rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(OutValid), 32'd0);
    check("arst_a", OperandA, 32'd0);
    check("arst_wreg", 32'(WriteReg), 32'd0);
    check("arst_rw", 32'(RegWrite), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
